// File: rtl/mul_sequencer_if.sv
// Request/response bundle between the CPU pipeline and the
// multi-cycle multiply sequencer.
interface mul_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            valid_i;
  logic [2:0]      op_i;
  logic            flush_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            ready_o;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, op_i, flush_i, a_i, b_i,
    input  ready_o, stall_o, done_o, result_o
  );

  modport slave (
    input  valid_i, op_i, flush_i, a_i, b_i,
    output ready_o, stall_o, done_o, result_o
  );
endinterface

// File: rtl/mul_sequencer.sv
// Shift-add multiplier controller beside the ALU: stalls the
// pipeline while iterating and pulses done with the low product.
module mul_sequencer #(
  parameter int unsigned XLEN       = 32,
  parameter logic [2:0]  MUL_CODE   = 3'b011,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mul_sequencer_if.slave bus
);
  localparam int unsigned CW = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_result;
  logic [CW-1:0]   r_count;

  logic            w_accept;
  logic            w_zero;
  logic            w_last;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_mplier_nxt;

  assign w_accept = (r_state == S_IDLE) & bus.valid_i
                  & (bus.op_i == MUL_CODE) & ~bus.flush_i;
  assign w_zero = EARLY_EXIT
                & ((bus.a_i == '0) | (bus.b_i == '0));
  assign w_sum = r_mplier[0] ? r_acc + r_mcand : r_acc;
  assign w_mplier_nxt = r_mplier >> 1;
  // Stop once no multiplier bits remain, or after XLEN steps.
  assign w_last = (EARLY_EXIT & (w_mplier_nxt == '0))
                | (r_count == CW'(XLEN - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      unique case (1'b1)
        (r_state == S_IDLE): begin
          if (w_accept) begin
            r_mcand  <= bus.a_i;
            r_mplier <= bus.b_i;
            r_acc    <= '0;
            r_count  <= '0;
            r_state  <= w_zero ? S_DONE : S_BUSY;
          end
        end
        (r_state == S_BUSY): begin
          if (bus.flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_nxt;
            r_count  <= r_count + 1'b1;
            if (w_last) r_state <= S_DONE;
          end
        end
        (r_state == S_DONE): begin
          r_result <= r_acc;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_o  = (r_state == S_IDLE);
  assign bus.stall_o  = (r_state == S_BUSY) | w_accept;
  assign bus.done_o   = (r_state == S_DONE);
  // Present the product in the retire cycle itself.
  assign bus.result_o = (r_state == S_DONE) ? r_acc : r_result;
endmodule

// File: tb/tb_mul_sequencer.sv
// Directed and random checks of mul_sequencer against a
// cycle-level timeline model of the multiply protocol.
module tb_mul_sequencer;
  localparam logic [2:0] MUL = 3'b011;
  localparam logic [2:0] ADD = 3'b000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v = 1'b0;
  logic        fl = 1'b0;
  logic [2:0]  op = ADD;
  logic [31:0] ai = '0;
  logic [31:0] bi = '0;
  bit          sel = 1'b0;
  int          c = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) c++;

  mul_sequencer_if #(.XLEN(32)) b0 ();
  mul_sequencer_if #(.XLEN(32)) b1 ();

  assign b0.valid_i = v & ~sel;
  assign b0.op_i    = op;
  assign b0.flush_i = fl;
  assign b0.a_i     = ai;
  assign b0.b_i     = bi;
  assign b1.valid_i = v & sel;
  assign b1.op_i    = op;
  assign b1.flush_i = fl;
  assign b1.a_i     = ai;
  assign b1.b_i     = bi;

  mul_sequencer #(.XLEN(32), .EARLY_EXIT(1'b1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b0)
  );

  mul_sequencer #(.XLEN(32), .EARLY_EXIT(1'b0)) dut_full (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b1)
  );

  logic        o_ready, o_stall, o_done;
  logic [31:0] o_res;
  assign o_ready = sel ? b1.ready_o  : b0.ready_o;
  assign o_stall = sel ? b1.stall_o  : b0.stall_o;
  assign o_done  = sel ? b1.done_o   : b0.done_o;
  assign o_res   = sel ? b1.result_o : b0.result_o;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @cycle %0d",
               nm, got, exp, c);
    end
  endtask

  function automatic int nlat(input logic [31:0] a,
                              input logic [31:0] b,
                              input bit ee);
    if (!ee) return 32;
    if (a == 0 || b == 0) return 0;
    for (int i = 31; i >= 0; i--)
      if (b[i]) return i + 1;
    return 0;
  endfunction

  // Timeline model: a request accepted in cycle T iterates
  // for n cycles and retires in cycle T+n+1.
  bit          known = 1'b0;
  bit          pend = 1'b0;
  int          mt = 0;
  int          mn = 0;
  logic [31:0] mprod = '0;
  logic [31:0] lres [2];
  bit          busy, donee, idle, acc, ee;

  always @(negedge clk) begin
    ee    = ~sel;
    busy  = pend && c >= mt + 1 && c <= mt + mn;
    donee = pend && c == mt + mn + 1;
    idle  = !busy && !donee;
    acc   = idle && v && op == MUL && !fl;
    if (known) begin
      chk("m_ready", {31'b0, o_ready}, {31'b0, idle});
      chk("m_stall", {31'b0, o_stall}, {31'b0, busy | acc});
      chk("m_done", {31'b0, o_done}, {31'b0, donee});
      chk("m_result", o_res, donee ? mprod : lres[sel]);
    end
    if (rst) begin
      known   = 1'b1;
      pend    = 1'b0;
      lres[0] = '0;
      lres[1] = '0;
    end else if (known) begin
      if (donee) begin
        lres[sel] = mprod;
        pend = 1'b0;
      end else if (busy && fl) begin
        pend = 1'b0;
      end else if (acc) begin
        pend  = 1'b1;
        mt    = c;
        mn    = nlat(ai, bi, ee);
        mprod = 32'(64'(ai) * 64'(bi));
      end
    end
  end

  task automatic mul(input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] er,
                     input int el,
                     input string nm);
    int t0;
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    v = 1'b1; op = MUL; fl = 1'b0;
    ai = a; bi = b; t0 = c;
    @(posedge clk); #1;
    ai = ~a; bi = b ^ 32'h5a5a_5a5a;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (o_done) begin
        got = 1'b1;
        chk({nm, "_lat"}, 32'(c - t0), 32'(el));
        chk({nm, "_res"}, o_res, er);
      end
    end
    if (!got) chk({nm, "_timeout"}, {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    v = 1'b0;
  endtask

  task automatic rnd(input logic [31:0] a,
                     input logic [31:0] b,
                     input int fa);
    bit fin;
    logic [31:0] p;
    fin = 1'b0;
    p = 32'(64'(a) * 64'(b));
    @(posedge clk); #1;
    v = 1'b1; op = MUL; fl = 1'b0;
    ai = a; bi = b;
    for (int k = 1; k <= 40 && !fin; k++) begin
      @(posedge clk); #1;
      ai = $urandom; bi = $urandom;
      fl = (fa != 0 && k == fa);
      if (fl) v = 1'b0;
      @(negedge clk);
      if (o_done) begin
        fin = 1'b1;
        chk("rnd_res", o_res, p);
      end else if (fa != 0 && k > fa) begin
        fin = 1'b1;
      end
    end
    if (!fin) chk("rnd_timeout", {31'b0, fin}, 32'd1);
    @(posedge clk); #1;
    v = 1'b0; fl = 1'b0;
  endtask

  initial begin
    int t0;
    logic [31:0] ra, rb;
    int fa;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, o_ready}, 32'd1);
    chk("rst_stall", {31'b0, o_stall}, 32'd0);
    chk("rst_done", {31'b0, o_done}, 32'd0);
    chk("rst_result", o_res, 32'd0);

    mul(32'd7, 32'd6, 32'd42, 4, "m7x6");
    mul(32'd0, 32'd5, 32'd0, 1, "a_zero");
    mul(32'd9, 32'd0, 32'd0, 1, "b_zero");

    @(posedge clk); #1;
    v = 1'b1; op = ADD; ai = 32'd3; bi = 32'd4;
    @(negedge clk);
    chk("add_stall", {31'b0, o_stall}, 32'd0);
    chk("add_done", {31'b0, o_done}, 32'd0);
    repeat (3) @(posedge clk);
    #1 v = 1'b0;

    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 33, "mff");
    mul(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 4, "mneg");

    @(posedge clk); #1;
    v = 1'b1; op = MUL; ai = 32'h1234; bi = 32'h1_0000;
    t0 = c;
    repeat (5) @(posedge clk);
    #1 fl = 1'b1; v = 1'b0;
    @(negedge clk);
    chk("fl_busy5", 32'(c - t0), 32'd5);
    chk("fl_stall", {31'b0, o_stall}, 32'd1);
    @(posedge clk); #1 fl = 1'b0;
    @(negedge clk);
    chk("fl_ready", {31'b0, o_ready}, 32'd1);
    chk("fl_keep", o_res, 32'hFFFF_FFF1);
    repeat (20) @(posedge clk);
    mul(32'd3, 32'd3, 32'd9, 3, "m3x3");

    @(posedge clk); #1;
    v = 1'b1; op = MUL; ai = 32'h1234; bi = 32'h1_0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; v = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_ready", {31'b0, o_ready}, 32'd1);
    chk("mrst_stall", {31'b0, o_stall}, 32'd0);
    chk("mrst_done", {31'b0, o_done}, 32'd0);
    chk("mrst_result", o_res, 32'd0);
    mul(32'd2, 32'd2, 32'd4, 3, "m2x2");

    @(posedge clk); #1 sel = 1'b1;
    mul(32'd7, 32'd6, 32'd42, 33, "full7x6");
    mul(32'd0, 32'd9, 32'd0, 33, "full_zero");

    for (int s = 0; s < 2; s++) begin
      @(posedge clk); #1 sel = (s == 0);
      for (int i = 0; i < 500; i++) begin
        ra = $urandom >> $urandom_range(0, 31);
        rb = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 15) == 0) ra = '0;
        if ($urandom_range(0, 15) == 0) rb = '0;
        fa = ($urandom_range(0, 7) == 0)
           ? $urandom_range(1, 34) : 0;
        rnd(ra, rb, fa);
      end
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
